// File: rtl/axi_range_reader_pkg.sv
// Shared types for the AXI range reader: FSM states, response codes and beat sizes.
package axi_range_reader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    RUN,
    DRAIN,
    DONE
  } state_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {
    SIZE_BYTE,
    SIZE_WORD,
    SIZE_DWORD,
    SIZE_QWORD
  } size_e;

endpackage

// File: rtl/range_reader_fifo.sv
// Response buffer: synchronous FIFO whose head is read straight from the storage registers.
module range_reader_fifo #(
  parameter int unsigned WIDTH = 33,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         data_o,
  output logic                     valid_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE = {{(PTR_W-1){1'b0}}, 1'b1};
  localparam logic [PTR_W:0]   CNT_ONE = {{PTR_W{1'b0}}, 1'b1};

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_q, rd_q;
  logic [PTR_W:0]   cnt_q;
  logic             do_push, do_pop;

  assign do_pop  = pop_i && (cnt_q != '0);
  assign do_push = push_i && ((32'(cnt_q) < DEPTH) || do_pop);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_q] <= data_i;
        wr_q        <= wr_q + PTR_ONE;
      end
      if (do_pop) rd_q <= rd_q + PTR_ONE;
      if (do_push && !do_pop)      cnt_q <= cnt_q + CNT_ONE;
      else if (do_pop && !do_push) cnt_q <= cnt_q - CNT_ONE;
    end
  end

  assign data_o  = mem_q[rd_q];
  assign valid_o = (cnt_q != '0);
  assign count_o = cnt_q;

endmodule

// File: rtl/axi_range_reader.sv
// AXI4-Lite read master sweeping [addr_begin, addr_end] with credit-limited outstanding reads.
module axi_range_reader
  import axi_range_reader_pkg::*;
#(
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned MAX_OUTST = 4
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  input  logic              abort_i,
  input  logic [ADDR_W-1:0] addr_begin_i,
  input  logic [ADDR_W-1:0] addr_end_i,
  input  logic [1:0]        size_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              error_o,
  output logic [ADDR_W-1:0] beats_o,
  output logic [ADDR_W-1:0] ar_addr_o,
  output logic [2:0]        ar_size_o,
  output logic              ar_valid_o,
  input  logic              ar_ready_i,
  input  logic [DATA_W-1:0] r_data_i,
  input  logic [1:0]        r_resp_i,
  input  logic              r_valid_i,
  output logic              r_ready_o,
  output logic [DATA_W-1:0] s_data_o,
  output logic [ADDR_W-1:0] s_addr_o,
  output logic              s_last_o,
  output logic              s_valid_o,
  input  logic              s_ready_i
);

  localparam int unsigned LANE_W = $clog2(DATA_W / 8);
  localparam int unsigned LSB_W  = (LANE_W > 0) ? LANE_W : 1;
  localparam int unsigned CNT_W  = $clog2(MAX_OUTST) + 1;
  localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]  CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  state_e            state_q, state_d;
  size_e             size_q, size_d;
  logic [ADDR_W-1:0] end_q, end_d, last_q, last_d;
  logic [ADDR_W-1:0] ar_addr_q, ar_addr_d, r_addr_q, r_addr_d, s_addr_q, s_addr_d;
  logic [ADDR_W-1:0] beats_q, beats_d;
  logic [CNT_W-1:0]  outst_q, outst_d;
  logic              err_q, err_d, disc_q, disc_d;

  logic [ADDR_W-1:0] step, span;
  logic [CNT_W-1:0]  fifo_cnt;
  logic [CNT_W:0]    used;
  logic [DATA_W-1:0] lane_mask, lane_data, fifo_data;
  logic [LSB_W+2:0]  lane_sh;
  logic              cfg_ok, credit, ar_hs, r_hs, r_ok, push, s_hs, fifo_valid, fifo_last;

  assign step   = ADDR_ONE << size_q;
  assign span   = end_q - ar_addr_q;
  assign cfg_ok = (32'(size_q) <= LANE_W) && ((ar_addr_q & (step - ADDR_ONE)) == '0)
               && (end_q >= ar_addr_q);

  assign busy_o     = (state_q == CHECK) || (state_q == RUN) || (state_q == DRAIN);
  assign used       = {1'b0, outst_q} + {1'b0, fifo_cnt};
  assign credit     = 32'(used) < MAX_OUTST;
  assign ar_valid_o = (state_q == RUN) && credit;
  assign ar_hs      = ar_valid_o && ar_ready_i;
  assign r_ready_o  = busy_o;
  assign r_hs       = r_valid_i && r_ready_o;
  assign r_ok       = (r_resp_i == RESP_OKAY);
  assign push       = r_hs && r_ok && !disc_q;
  assign s_hs       = fifo_valid && s_ready_i;

  // R beats return in issue order, so r_addr_q always names the lane of the incoming beat.
  assign lane_sh   = (LANE_W == 0) ? '0 : {r_addr_q[LSB_W-1:0], 3'b000};
  assign lane_mask = ~({DATA_W{1'b1}} << (8 << size_q));
  assign lane_data = (r_data_i >> lane_sh) & lane_mask;

  range_reader_fifo #(
    .WIDTH (DATA_W + 1),
    .DEPTH (MAX_OUTST)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (push),
    .data_i  ({r_addr_q == last_q, lane_data}),
    .pop_i   (s_ready_i),
    .data_o  ({fifo_last, fifo_data}),
    .valid_o (fifo_valid),
    .count_o (fifo_cnt)
  );

  always_comb begin
    state_d   = state_q;
    size_d    = size_q;
    end_d     = end_q;
    last_d    = last_q;
    ar_addr_d = ar_hs ? ar_addr_q + step : ar_addr_q;
    r_addr_d  = r_hs ? r_addr_q + step : r_addr_q;
    s_addr_d  = s_hs ? s_addr_q + step : s_addr_q;
    beats_d   = s_hs ? beats_q + ADDR_ONE : beats_q;
    outst_d   = outst_q;
    err_d     = err_q;
    disc_d    = disc_q;
    done_o    = 1'b0;

    if (ar_hs && !r_hs)      outst_d = outst_q + CNT_ONE;
    else if (r_hs && !ar_hs) outst_d = outst_q - CNT_ONE;
    if (r_hs && !r_ok) begin
      err_d  = 1'b1;
      disc_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d   = CHECK;
          size_d    = size_e'(size_i);
          end_d     = addr_end_i;
          ar_addr_d = addr_begin_i;
          r_addr_d  = addr_begin_i;
          s_addr_d  = addr_begin_i;
          beats_d   = '0;
          err_d     = 1'b0;
          disc_d    = 1'b0;
        end
      end
      CHECK: begin
        if (cfg_ok) begin
          state_d = RUN;
          last_d  = ar_addr_q + ((span >> size_q) << size_q);
        end else begin
          state_d = DONE;
          err_d   = 1'b1;
        end
      end
      RUN: begin
        // Accepting the final AR wins over a coincident abort: the sweep completes normally.
        if (ar_hs && (ar_addr_q == last_q)) begin
          state_d = DRAIN;
        end else if (abort_i || (r_hs && !r_ok)) begin
          state_d = DRAIN;
          disc_d  = 1'b1;
        end
      end
      DRAIN: begin
        if ((outst_q == '0) && !fifo_valid) state_d = DONE;
      end
      DONE: begin
        done_o  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      size_q    <= SIZE_BYTE;
      end_q     <= '0;
      last_q    <= '0;
      ar_addr_q <= '0;
      r_addr_q  <= '0;
      s_addr_q  <= '0;
      beats_q   <= '0;
      outst_q   <= '0;
      err_q     <= 1'b0;
      disc_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      size_q    <= size_d;
      end_q     <= end_d;
      last_q    <= last_d;
      ar_addr_q <= ar_addr_d;
      r_addr_q  <= r_addr_d;
      s_addr_q  <= s_addr_d;
      beats_q   <= beats_d;
      outst_q   <= outst_d;
      err_q     <= err_d;
      disc_q    <= disc_d;
    end
  end

  assign error_o   = err_q;
  assign beats_o   = beats_q;
  assign ar_addr_o = ar_addr_q;
  assign ar_size_o = {1'b0, size_q};
  assign s_data_o  = fifo_data;
  assign s_addr_o  = s_addr_q;
  assign s_valid_o = fifo_valid;
  assign s_last_o  = fifo_valid && fifo_last;

endmodule

// File: doc/axi_range_reader.md
Name: axi_range_reader

Overview:
- Synthesizable AXI4-Lite-style read master that sweeps an inclusive address range [addr_begin, addr_end] with a programmable beat size.
- Keeps up to MAX_OUTST reads in flight and delivers each beat, tagged with its address, on a valid/ready stream.
- Replaces the fixed-size, one-read-at-a-time, testbench-only memory dump loop with hardware usable in front of the Renode-backed memory or real SoC memory.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, read data width; power of two, 8..64.
- MAX_OUTST, 4, maximum outstanding AR requests; also the depth of the response buffer (power of two, >=2).

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- start_i  in  1  one-cycle start pulse; ignored unless idle
- abort_i  in  1  stop issuing and drain
- addr_begin_i  in  ADDR_W  first address, sampled at start
- addr_end_i  in  ADDR_W  inclusive last address, sampled at start
- size_i  in  2  log2 bytes per beat: 0=byte, 1=Word(2), 2=DoubleWord(4), 3=QuadWord(8); sampled at start
- busy_o  out  1  sweep in progress
- done_o  out  1  one-cycle pulse at end of sweep
- error_o  out  1  sticky; cleared by the next accepted start
- beats_o  out  ADDR_W  beats delivered in the current/last sweep
- ar_addr_o  out  ADDR_W  read address
- ar_size_o  out  3  equals {1'b0, size}
- ar_valid_o  out  1
- ar_ready_i  in  1
- r_data_i  in  DATA_W
- r_resp_i  in  2  00 OKAY, 10 SLVERR, 11 DECERR
- r_valid_i  in  1
- r_ready_o  out  1
- s_data_o  out  DATA_W  beat data
- s_addr_o  out  ADDR_W  address of beat
- s_last_o  out  1  final beat of sweep
- s_valid_o  out  1
- s_ready_i  in  1

Behaviour:
- Reset:
  - All outputs 0; FSM in IDLE.
  - Reset asserted mid-sweep abandons it; no done_o pulse is generated.
- FSM states:
  - IDLE -> CHECK on start_i.
  - CHECK (1 cycle) -> RUN if valid; otherwise DONE with error_o=1 and no AR issued.
  - RUN -> DRAIN when the last AR is accepted, or on abort_i, or on an error response.
  - DRAIN -> DONE when the outstanding count is 0 and the buffer is empty.
  - DONE (1 cycle, done_o=1) -> IDLE.
- CHECK fails when:
  - size_i > log2(DATA_W/8), or
  - addr_begin_i is not aligned to the beat size, or
  - addr_end_i < addr_begin_i.
- busy_o = 1 in CHECK, RUN and DRAIN.
- AR issue:
  - ar_valid_o only in RUN, and only when outstanding + buffer occupancy < MAX_OUTST (credit rule, so R never backs up).
  - ar_addr_o/ar_valid_o stay stable until ar_ready_i.
  - Address advances by 2^size per accepted AR.
  - The last address is the largest begin + k*2^size <= end.
  - The last-address compare is done before incrementing, so a range ending at 2^ADDR_W - 2^size completes without wrap.
- R channel:
  - r_ready_o = 1 whenever busy_o (guaranteed by credits).
  - OKAY beats are pushed to the buffer.
  - A non-OKAY beat sets error_o, is discarded, and forces DRAIN.
  - Once error or abort is seen, all further R beats are discarded but still counted down from outstanding.
- Stream:
  - s_data_o = r_data_i lane-extracted by the beat's addr[log2(DATA_W/8)-1:0], zero-extended.
  - s_addr_o counter starts at begin and advances by 2^size per handshake.
  - s_last_o is set on the final beat of a full sweep; it is never set after error or abort.
  - s_valid_o/s_data_o are held stable until s_ready_i.
  - Beats already buffered at abort or error are still delivered.
- Latency:
  - start to first ar_valid_o: 2 cycles.
  - R handshake to s_valid_o: 1 cycle (registered buffer output).
- beats_o increments per stream handshake and is cleared on an accepted start.
- Simultaneous events:
  - abort_i in the same cycle as the last AR accept: treated as normal completion.
  - R beat and stream pop in the same cycle: occupancy unchanged.
  - AR accept and R beat in the same cycle: outstanding unchanged.

Decomposition:
- Package axi_range_reader_pkg holds:
  - state enum: IDLE, CHECK, RUN, DRAIN, DONE;
  - resp constants: RESP_OKAY, RESP_SLVERR, RESP_DECERR;
  - size enum mirroring Byte/Word/DoubleWord/QuadWord.
- Sub-module range_reader_fifo: synchronous FIFO, depth MAX_OUTST, registered output.
  - Width DATA_W+1 (data plus a last flag); the stream address is tracked outside the FIFO.

Test Plan:
- begin=0x10, end=0x20, size=2, DATA_W=32, zero-wait slave returning mem[a]=a+0x100 -> 5 beats at 0x10..0x20, data 0x110..0x120, s_last on 0x20, done_o pulse, beats_o=5, error_o=0.
- Same sweep with s_ready_i low for 20 cycles mid-sweep and slave R latency 3 -> outstanding never exceeds 4; no data loss or reorder; ar_valid_o deasserts while credits are exhausted.
- begin=0x10, end=0x1E, size=2 -> last beat 0x1C (4 beats); size=1, end=0x13 -> 2 beats 0x10, 0x12 with correct 16-bit lane extraction.
- Slave returns SLVERR on 0x18 with 3 reads in flight -> error_o=1; beats 0x10, 0x14 delivered; no s_last; remaining R beats consumed; done_o once; next start clears error_o.
- Invalid configurations: begin=0x12 size=2, end<begin, size=3 with DATA_W=32 -> no AR issued; done_o 2 cycles after start; error_o=1.
- abort_i asserted after the 2nd AR accept; rst_ni low mid-RUN -> abort case drains and pulses done_o with error_o=0 and no s_last; reset case drops all outputs to 0 immediately.
